// File: rtl/nn_seq_pkg.sv
// Shared types and constants for the NN sample sequencer: the sequencer FSM
// encoding, the core's overflow marker and the core FSM-state codes.
package nn_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLD    = 3'd4
  } seq_state_t;

  // The core saturates final_output to all-ones on overflow; passed through untouched.
  localparam logic [31:0] OVF_MARKER = 32'hFFFF_FFFF;

  // Codes reported by the core on ovf_fsm_state / zero_fsm_state.
  typedef enum logic [2:0] {
    NN_CORE_S0 = 3'd0,
    NN_CORE_S1 = 3'd1,
    NN_CORE_S2 = 3'd2,
    NN_CORE_S3 = 3'd3,
    NN_CORE_S4 = 3'd4,
    NN_CORE_S5 = 3'd5,
    NN_CORE_S6 = 3'd6
  } nn_core_state_t;

  function automatic logic [2:0] select_state_tag(
    input logic       ovf,
    input logic [2:0] ovf_state,
    input logic [2:0] zero_state
  );
    return ovf ? ovf_state : zero_state;
  endfunction

endpackage

// File: rtl/nn_sample_fifo.sv
// Synchronous FIFO holding sample pairs; extra pointer MSB distinguishes
// full from empty. Head entry is visible without a read request.
module nn_sample_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Storage carries no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign head_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/nn_sample_sequencer.sv
// Feeds buffered sample pairs to the 2-2-1 NN core one at a time, waits the
// core latency, and presents each captured result on a valid/ready stream.
module nn_sample_sequencer
  import nn_seq_pkg::*;
#(
  parameter int DATAWIDTH     = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int FIRST_LATENCY = 10,
  parameter int RUN_LATENCY   = 5,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data1,
  input  logic [DATAWIDTH-1:0] in_data2,
  output logic [DATAWIDTH-1:0] nn_input_1,
  output logic [DATAWIDTH-1:0] nn_input_2,
  output logic                 nn_enable,
  input  logic [DATAWIDTH-1:0] nn_final_output,
  input  logic                 nn_total_ovf,
  input  logic                 nn_total_zero,
  input  logic [2:0]           nn_ovf_state,
  input  logic [2:0]           nn_zero_state,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_ovf,
  output logic                 out_zero,
  output logic [2:0]           out_state,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic [CNT_WIDTH-1:0] ovf_count,
  output logic                 busy
);

  localparam int LAT_MAX = (FIRST_LATENCY > RUN_LATENCY) ? FIRST_LATENCY : RUN_LATENCY;
  localparam int CW      = $clog2(LAT_MAX + 1);
  localparam logic [CW-1:0] FIRST_LOAD = CW'(FIRST_LATENCY - 1);
  localparam logic [CW-1:0] RUN_LOAD   = CW'(RUN_LATENCY - 1);

  seq_state_t            state_reg, state_next;
  logic [CW-1:0]         wait_cnt_reg, wait_cnt_next;
  logic                  first_done_reg, first_done_next;
  logic [DATAWIDTH-1:0]  nn_input_1_reg, nn_input_1_next;
  logic [DATAWIDTH-1:0]  nn_input_2_reg, nn_input_2_next;
  logic                  out_valid_reg, out_valid_next;
  logic [DATAWIDTH-1:0]  out_data_reg, out_data_next;
  logic                  out_ovf_reg, out_ovf_next;
  logic                  out_zero_reg, out_zero_next;
  logic [2:0]            out_state_reg, out_state_next;
  logic [CNT_WIDTH-1:0]  sample_count_reg, sample_count_next;
  logic [CNT_WIDTH-1:0]  ovf_count_reg, ovf_count_next;

  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [2*DATAWIDTH-1:0] fifo_head;

  nn_sample_fifo #(
    .WIDTH (2*DATAWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (in_valid),
    .push_data ({in_data1, in_data2}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next        = state_reg;
    wait_cnt_next     = wait_cnt_reg;
    first_done_next   = first_done_reg;
    nn_input_1_next   = nn_input_1_reg;
    nn_input_2_next   = nn_input_2_reg;
    out_valid_next    = out_valid_reg;
    out_data_next     = out_data_reg;
    out_ovf_next      = out_ovf_reg;
    out_zero_next     = out_zero_reg;
    out_state_next    = out_state_reg;
    sample_count_next = sample_count_reg;
    ovf_count_next    = ovf_count_reg;
    fifo_pop          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          nn_input_1_next = fifo_head[2*DATAWIDTH-1:DATAWIDTH];
          nn_input_2_next = fifo_head[DATAWIDTH-1:0];
          fifo_pop        = 1'b1;
          state_next      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_cnt_next = first_done_reg ? RUN_LOAD : FIRST_LOAD;
        state_next    = ST_WAIT;
      end
      ST_WAIT: begin
        // Leaving on the 1 -> 0 step lands CAPTURE exactly latency cycles after ISSUE.
        if (wait_cnt_reg <= CW'(1)) begin
          wait_cnt_next = '0;
          state_next    = ST_CAPTURE;
        end else begin
          wait_cnt_next = wait_cnt_reg - CW'(1);
        end
      end
      ST_CAPTURE: begin
        out_data_next   = nn_final_output;
        out_ovf_next    = nn_total_ovf;
        out_zero_next   = nn_total_zero;
        out_state_next  = select_state_tag(nn_total_ovf, nn_ovf_state, nn_zero_state);
        out_valid_next  = 1'b1;
        first_done_next = 1'b1;
        state_next      = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          if (sample_count_reg != '1) sample_count_next = sample_count_reg + CNT_WIDTH'(1);
          if (out_ovf_reg && (ovf_count_reg != '1)) ovf_count_next = ovf_count_reg + CNT_WIDTH'(1);
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_reg        <= ST_IDLE;
      wait_cnt_reg     <= '0;
      first_done_reg   <= 1'b0;
      nn_input_1_reg   <= '0;
      nn_input_2_reg   <= '0;
      out_valid_reg    <= 1'b0;
      out_data_reg     <= '0;
      out_ovf_reg      <= 1'b0;
      out_zero_reg     <= 1'b0;
      out_state_reg    <= '0;
      sample_count_reg <= '0;
      ovf_count_reg    <= '0;
    end else begin
      state_reg        <= state_next;
      wait_cnt_reg     <= wait_cnt_next;
      first_done_reg   <= first_done_next;
      nn_input_1_reg   <= nn_input_1_next;
      nn_input_2_reg   <= nn_input_2_next;
      out_valid_reg    <= out_valid_next;
      out_data_reg     <= out_data_next;
      out_ovf_reg      <= out_ovf_next;
      out_zero_reg     <= out_zero_next;
      out_state_reg    <= out_state_next;
      sample_count_reg <= sample_count_next;
      ovf_count_reg    <= ovf_count_next;
    end
  end

  assign in_ready     = !fifo_full;
  assign nn_input_1   = nn_input_1_reg;
  assign nn_input_2   = nn_input_2_reg;
  assign nn_enable    = (state_reg == ST_ISSUE);
  assign out_valid    = out_valid_reg;
  assign out_data     = out_data_reg;
  assign out_ovf      = out_ovf_reg;
  assign out_zero     = out_zero_reg;
  assign out_state    = out_state_reg;
  assign sample_count = sample_count_reg;
  assign ovf_count    = ovf_count_reg;
  assign busy         = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_nn_sample_sequencer.sv
// Bench for nn_sample_sequencer: plays the NN core (result valid only on the
// latency cycle) and checks every cycle against a queue-based model.
module tb_nn_sample_sequencer;

  localparam int DW        = 32;
  localparam int DEPTH     = 4;
  localparam int FIRST_LAT = 10;
  localparam int RUN_LAT   = 5;
  localparam int CNTW      = 16;

  logic            clk = 1'b0;
  logic            resetn;
  logic            in_valid, in_ready;
  logic [DW-1:0]   in_data1, in_data2;
  logic [DW-1:0]   nn_input_1, nn_input_2;
  logic            nn_enable;
  logic [DW-1:0]   nn_final_output;
  logic            nn_total_ovf, nn_total_zero;
  logic [2:0]      nn_ovf_state, nn_zero_state;
  logic            out_valid, out_ready;
  logic [DW-1:0]   out_data;
  logic            out_ovf, out_zero;
  logic [2:0]      out_state;
  logic [CNTW-1:0] sample_count, ovf_count;
  logic            busy;

  nn_sample_sequencer #(
    .DATAWIDTH(DW), .FIFO_DEPTH(DEPTH), .FIRST_LATENCY(FIRST_LAT),
    .RUN_LATENCY(RUN_LAT), .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data1(in_data1), .in_data2(in_data2), .nn_input_1(nn_input_1),
    .nn_input_2(nn_input_2), .nn_enable(nn_enable), .nn_final_output(nn_final_output),
    .nn_total_ovf(nn_total_ovf), .nn_total_zero(nn_total_zero),
    .nn_ovf_state(nn_ovf_state), .nn_zero_state(nn_zero_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_zero(out_zero), .out_state(out_state),
    .sample_count(sample_count), .ovf_count(ovf_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Core transfer function used by the bench's stand-in core.
  function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, r;
    sa = a; sb = b;
    r = sa * 2 + sb * 3 + 32'sd7;
    return r;
  endfunction

  typedef struct { logic [31:0] a; logic [31:0] b; } pair_t;

  pair_t       pend_q[$];
  pair_t       p;
  int          occ = 0;
  bit          inflight = 0;
  bit          core_first = 1;
  bit          force_ovf = 0;
  int          e_cyc = 0, res_cyc = -1, core_lat = 0, last_acc_cyc = 0;
  logic [31:0] exp_data = '0;
  logic        exp_ovf = 1'b0, exp_zero = 1'b0;
  logic [2:0]  exp_state = '0;
  logic        prev_valid = 1'b0;
  logic [31:0] snap_data;
  logic        snap_ovf, snap_zero;
  logic [2:0]  snap_state;
  int          samples = 0, ovfs = 0, enables = 0, delivered = 0;
  int          not_ready_cycles = 0, enable_gap = 0, last_lat = 0;
  logic [31:0] last_data = '0;
  logic        last_ovf = 1'b0;
  logic [2:0]  last_state = '0;

  always @(negedge clk) begin
    if (resetn) begin
      pend_q.delete();
      occ = 0; inflight = 0; core_first = 1; res_cyc = -1;
      prev_valid = 1'b0; samples = 0; ovfs = 0;
    end else begin
      if (nn_enable) begin
        chk("enable_while_result_pending", 32'(inflight), 32'd0);
        chk("enable_with_queued_sample", 32'(pend_q.size() > 0), 32'd1);
        if (pend_q.size() > 0) begin
          p = pend_q.pop_front();
          chk("nn_input_1", nn_input_1, p.a);
          chk("nn_input_2", nn_input_2, p.b);
          occ--;
          exp_data = force_ovf ? 32'hFFFF_FFFF : core_fn(p.a, p.b);
          exp_ovf  = force_ovf;
          exp_zero = !force_ovf && (exp_data == 32'd0);
          exp_state = exp_ovf ? 3'd3 : (exp_zero ? 3'd4 : 3'd6);
        end
        inflight = 1; e_cyc = cyc; enable_gap = cyc - last_acc_cyc;
        core_lat = core_first ? FIRST_LAT : RUN_LAT;
        core_first = 0; res_cyc = cyc + core_lat; enables++;
      end
      chk("in_ready", 32'(in_ready), 32'(occ < DEPTH));
      chk("busy", 32'(busy), 32'(inflight || occ > 0));
      chk("sample_count", 32'(sample_count), 32'(samples));
      chk("ovf_count", 32'(ovf_count), 32'(ovfs));
      if (!in_ready) not_ready_cycles++;
      if (out_valid && !prev_valid) begin
        chk("valid_has_result", 32'(inflight), 32'd1);
        last_lat = cyc - (e_cyc - 1);
        chk("result_latency", last_lat, core_lat + 2);
        snap_data = out_data; snap_ovf = out_ovf; snap_zero = out_zero; snap_state = out_state;
      end else if (out_valid && prev_valid) begin
        chk("stall_out_data", out_data, snap_data);
        chk("stall_out_ovf", 32'(out_ovf), 32'(snap_ovf));
        chk("stall_out_zero", 32'(out_zero), 32'(snap_zero));
        chk("stall_out_state", 32'(out_state), 32'(snap_state));
      end
      if (out_valid && out_ready) begin
        chk("out_data", out_data, exp_data);
        chk("out_ovf", 32'(out_ovf), 32'(exp_ovf));
        chk("out_zero", 32'(out_zero), 32'(exp_zero));
        chk("out_state", 32'(out_state), 32'(exp_state));
        last_data = out_data; last_ovf = out_ovf; last_state = out_state;
        if (samples < 65535) samples++;
        if (exp_ovf && ovfs < 65535) ovfs++;
        inflight = 0; delivered++;
      end
      prev_valid = out_valid;
      if (in_valid && in_ready) begin
        pend_q.push_back('{a: in_data1, b: in_data2});
        occ++; last_acc_cyc = cyc;
      end
    end
    // Stand-in core: correct result only on its latency cycle, decoys otherwise.
    if (!resetn && cyc == res_cyc) begin
      nn_final_output = exp_data; nn_total_ovf = exp_ovf; nn_total_zero = exp_zero;
      nn_ovf_state = exp_ovf ? 3'd3 : 3'd2; nn_zero_state = exp_zero ? 3'd4 : 3'd6;
    end else begin
      nn_final_output = 32'hA5A5_0000 | 32'(cyc[15:0]);
      nn_total_ovf = !exp_ovf; nn_total_zero = !exp_zero;
      nn_ovf_state = 3'd7; nn_zero_state = 3'd7;
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    in_valid = 1'b1; in_data1 = a; in_data2 = b;
    @(negedge clk);
    while (!in_ready && t < 500) begin @(negedge clk); t++; end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL push_timeout: in_ready stuck low, required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_delivered(input int n);
    int t = 0;
    while (delivered < n && t < 500) begin @(posedge clk); t++; end
    if (delivered < n) begin
      n_checks++;
      $display("FAIL result_timeout: got %0d results, required %0d", delivered, n);
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] burst_a [6] = '{32'd1, 32'hFFFF_FFFC, 32'd10, 32'd0, 32'hFFFF_FF9C, 32'd7};
  logic [31:0] burst_b [6] = '{32'hFFFF_FFFD, 32'd2, 32'd20, 32'd0, 32'd50, 32'hFFFF_FFFF};

  initial begin
    int nr0, en0, en_target, t;
    in_valid = 1'b0; in_data1 = '0; in_data2 = '0; out_ready = 1'b0; resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_nn_enable", 32'(nn_enable), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    out_ready = 1'b1;
    push(32'd3, 32'hFFFF_FFFE);
    wait_delivered(1);
    chk("first_data", last_data, 32'd7);
    chk("first_latency", last_lat, 32'd12);
    chk("first_enable_gap", enable_gap, 32'd2);
    chk("first_sample_count", 32'(sample_count), 32'd1);
    chk("first_enable_count", enables, 32'd1);

    push(32'd100, 32'd7);
    wait_delivered(2);
    chk("second_data", last_data, 32'd228);
    chk("second_latency", last_lat, 32'd7);
    chk("second_enable_gap", enable_gap, 32'd2);

    nr0 = not_ready_cycles;
    for (int i = 0; i < 6; i++) push(burst_a[i], burst_b[i]);
    wait_delivered(8);
    chk("burst_backpressure_seen", 32'(not_ready_cycles > nr0), 32'd1);
    chk("burst_sample_count", 32'(sample_count), 32'd8);

    out_ready = 1'b0;
    push(32'd5, 32'd6);
    push(32'd1, 32'd1);
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    en0 = enables;
    repeat (20) @(posedge clk);
    #1;
    chk("hold_no_new_enable", enables, en0);
    chk("hold_valid_kept", 32'(out_valid), 32'd1);
    chk("hold_no_delivery", delivered, 32'd8);
    out_ready = 1'b1;
    wait_delivered(9);
    chk("hold_data", last_data, 32'd35);
    wait_delivered(10);
    chk("hold_sample_count", 32'(sample_count), 32'd10);

    force_ovf = 1;
    push(32'd9, 32'd9);
    wait_delivered(11);
    force_ovf = 0;
    chk("ovf_data", last_data, 32'hFFFF_FFFF);
    chk("ovf_flag", 32'(last_ovf), 32'd1);
    chk("ovf_state", 32'(last_state), 32'd3);
    chk("ovf_count", 32'(ovf_count), 32'd1);

    en_target = enables + 1;
    push(32'd11, 32'd1);
    push(32'd12, 32'd2);
    push(32'd13, 32'd3);
    t = 0;
    while (enables < en_target && t < 100) begin @(negedge clk); t++; end
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1 resetn = 1'b0;
    #1;
    chk("midrun_reset_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_reset_in_ready", 32'(in_ready), 32'd1);
    chk("midrun_reset_busy", 32'(busy), 32'd0);
    chk("midrun_reset_count", 32'(sample_count), 32'd0);
    en0 = enables;
    repeat (5) @(posedge clk);
    #1;
    chk("midrun_reset_queue_dropped", enables, en0);

    push(32'd2, 32'd3);
    wait_delivered(delivered + 1);
    chk("post_reset_latency", last_lat, 32'd12);
    chk("post_reset_data", last_data, 32'd20);
    chk("post_reset_count", 32'(sample_count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
